leiwand_rv32_wb_decoder: RTL and testbench

- Wishbone (pipelined, stall-capable) address decoder and response router between `leiwand_rv32_core` (master) and two `leiwand_rv32_ram` slaves (SRAM, ROM).
- Replaces the ad-hoc OR-combining of slave responses with:
  - registered slave selection;
  - single-outstanding transaction tracking;
  - an error response for unmapped addresses;
  - a bus-timeout watchdog, so the core never hangs.

---
 rtl/leiwand_rv32_wb_decoder.sv | 122 ++++++++++++
 tb/tb_leiwand_rv32_wb_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_wb_decoder.sv
// leiwand_rv32_wb_decoder: Wishbone decoder/router for SRAM+ROM with unmapped-address errors and ack timeout.
// Define LEIWAND_RV32_WB_DECODER_ERR_STATS_EN to add the err_count/err_addr error statistics outputs.
module leiwand_rv32_wb_decoder #(
    parameter int                   MEM_WIDTH = 32,
    parameter logic [MEM_WIDTH-1:0] S0_BASE   = 32'h10000000,
    parameter int                   S0_WORDS  = 128,
    parameter logic [MEM_WIDTH-1:0] S1_BASE   = 32'h20000000,
    parameter int                   S1_WORDS  = 128,
    parameter int                   TIMEOUT   = 16,
    parameter logic [MEM_WIDTH-1:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_cyc,
    input  logic                 m_stb,
    input  logic                 m_we,
    input  logic [MEM_WIDTH-1:0] m_addr,
    input  logic [MEM_WIDTH-1:0] m_wdata,
    output logic [MEM_WIDTH-1:0] m_rdata,
    output logic                 m_ack,
    output logic                 m_err,
    output logic                 m_stall,
    output logic                 s_we,
    output logic                 s_cyc,
    output logic [MEM_WIDTH-1:0] s_addr,
    output logic [MEM_WIDTH-1:0] s_wdata,
    output logic                 s0_stb,
    input  logic [MEM_WIDTH-1:0] s0_rdata,
    input  logic                 s0_ack,
    input  logic                 s0_stall,
    output logic                 s1_stb,
    input  logic [MEM_WIDTH-1:0] s1_rdata,
    input  logic                 s1_ack,
    input  logic                 s1_stall
`ifdef LEIWAND_RV32_WB_DECODER_ERR_STATS_EN
    ,
    output logic [15:0]          err_count,
    output logic [MEM_WIDTH-1:0] err_addr
`endif
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [MEM_WIDTH:0] S0_END = {1'b0, S0_BASE} + (MEM_WIDTH+1)'(4 * S0_WORDS);
    localparam logic [MEM_WIDTH:0] S1_END = {1'b0, S1_BASE} + (MEM_WIDTH+1)'(4 * S1_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, ERR_ACK} state_t;

    state_t               state;
    logic                 sel;
    logic [CW-1:0]        cnt;
    logic [MEM_WIDTH:0]   addr_x;
    logic                 hit0, hit1, miss, idle, req, accept, sel_ack, timeout;
    logic [MEM_WIDTH-1:0] sel_rdata;

    // hit1 is masked by hit0 so overlapping regions resolve to slave 0
    assign addr_x  = {1'b0, m_addr};
    assign hit0    = addr_x >= {1'b0, S0_BASE} && addr_x < S0_END;
    assign hit1    = !hit0 && addr_x >= {1'b0, S1_BASE} && addr_x < S1_END;
    assign miss    = !hit0 && !hit1;

    assign idle    = state == IDLE;
    assign req     = reset && idle && m_cyc && m_stb;
    assign s0_stb  = req && hit0;
    assign s1_stb  = req && hit1;
    assign m_stall = reset && (!idle || (hit0 ? s0_stall : hit1 && s1_stall));
    assign accept  = req && !m_stall;

    assign sel_ack   = sel ? s1_ack : s0_ack;
    assign sel_rdata = sel ? s1_rdata : s0_rdata;
    assign timeout   = state == WAIT_ACK && m_cyc && !sel_ack && cnt == CW'(TIMEOUT - 1);

    assign m_ack   = (state == WAIT_ACK && m_cyc && sel_ack) || state == ERR_ACK;
    assign m_err   = state == ERR_ACK;
    assign m_rdata = m_err ? ERR_DATA : m_ack ? sel_rdata : '0;

    assign s_we    = m_we;
    assign s_cyc   = m_cyc;
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= miss ? ERR_ACK : WAIT_ACK;
                    sel   <= hit1;
                    cnt   <= '0;
                end
                WAIT_ACK: begin
                    state <= (!m_cyc || sel_ack) ? IDLE : timeout ? ERR_ACK : WAIT_ACK;
                    cnt   <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEIWAND_RV32_WB_DECODER_ERR_STATS_EN
    logic [MEM_WIDTH-1:0] acc_addr;
    logic                 err_entry;

    assign err_entry = (accept && miss) || timeout;

    // a timed-out transfer reports the address captured when it was accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_addr  <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            if (accept) acc_addr <= m_addr;
            if (err_entry) begin
                err_count <= err_count + 16'(err_count != 16'hFFFF);
                err_addr  <= idle ? m_addr : acc_addr;
            end
        end
    end
`endif
endmodule

// File: tb/tb_leiwand_rv32_wb_decoder.sv
// tb_leiwand_rv32_wb_decoder: table-driven transfers with a response scoreboard plus reset/abort/stats sequences.
module tb_leiwand_rv32_wb_decoder;
    localparam int W = 32;
    localparam logic [W-1:0] ERRD = 32'hDEADBEEF;

    logic         clk = 1'b0, reset = 1'b0;
    logic         m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [W-1:0] m_addr = '0, m_wdata = '0;
    logic [W-1:0] m_rdata, s_addr, s_wdata;
    logic         m_ack, m_err, m_stall, s_we, s_cyc, s0_stb, s1_stb;
    logic [W-1:0] s0_rdata = '0, s1_rdata = '0;
    logic         s0_ack = 1'b0, s1_ack = 1'b0, s0_stall = 1'b0, s1_stall = 1'b0;
`ifdef LEIWAND_RV32_WB_DECODER_ERR_STATS_EN
    logic [15:0]  err_count;
    logic [W-1:0] err_addr;
`endif

    int n_checks = 0, n_fail = 0;

    typedef struct {
        logic         we;
        logic [W-1:0] addr, wdata;
        int           tgt, stall, lat;
        logic [W-1:0] srd;
        bit           other_ack, late_ack;
        int           exp_lat;
        logic         exp_err;
        logic [W-1:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [W-1:0] rd;
        logic         err;
        int           lat;
    } resp_t;

    resp_t sb[$];
    vec_t  tbl[12];

    always #5 clk = ~clk;

    leiwand_rv32_wb_decoder dut (
        .clk(clk), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
        .s_we(s_we), .s_cyc(s_cyc), .s_addr(s_addr), .s_wdata(s_wdata),
        .s0_stb(s0_stb), .s0_rdata(s0_rdata), .s0_ack(s0_ack), .s0_stall(s0_stall),
        .s1_stb(s1_stb), .s1_rdata(s1_rdata), .s1_ack(s1_ack), .s1_stall(s1_stall)
`ifdef LEIWAND_RV32_WB_DECODER_ERR_STATS_EN
        , .err_count(err_count), .err_addr(err_addr)
`endif
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                                input int tgt, input int stall, input int lat, input logic [W-1:0] srd,
                                input bit oa, input bit la, input int el, input logic ee,
                                input logic [W-1:0] er);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.tgt = tgt; v.stall = stall; v.lat = lat;
        v.srd = srd; v.other_ack = oa; v.late_ack = la; v.exp_lat = el; v.exp_err = ee; v.exp_rd = er;
        return v;
    endfunction

    task automatic set_slave(input int tgt, input logic ack, input logic [W-1:0] rd);
        if (tgt == 0) begin
            s0_ack = ack;
            s0_rdata = rd;
        end else if (tgt == 1) begin
            s1_ack = ack;
            s1_rdata = rd;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"}, m_ack, 0);
        chk({tag, "_err"}, m_err, 0);
        chk({tag, "_rdata"}, m_rdata, 0);
        chk({tag, "_s0_stb"}, s0_stb, 0);
        chk({tag, "_s1_stb"}, s1_stb, 0);
        chk({tag, "_stall"}, m_stall, 0);
    endtask

    // Called at a negedge; returns at a negedge with the bus idle.
    task automatic xfer(input vec_t v);
        int    stalls = 0;
        bit    acc = 0, bad_stb = 0, got = 0, extra = 0;
        resp_t r;
        m_cyc = 1; m_stb = 1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata;
        for (int i = 0; i < 10 && !acc; i++) begin
            s0_stall = (v.tgt == 0) && (i < v.stall);
            s1_stall = (v.tgt == 1) && (i < v.stall);
            #1;
            if (s0_stb !== (v.tgt == 0) || s1_stb !== (v.tgt == 1)) bad_stb = 1;
            if (m_stall) stalls++;
            else begin
                acc = 1;
                sb.push_back('{rd: v.exp_rd, err: v.exp_err, lat: v.exp_lat});
            end
            @(negedge clk);
        end
        chk("stb_route", W'(bad_stb), 0);
        chk("stall_cycles", W'(stalls), W'(v.stall));
        chk("accepted", W'(acc), 1);
        m_stb = 0; s0_stall = 0; s1_stall = 0;
        for (int k = 1; k <= 30 && acc && !got; k++) begin
            if (v.other_ack) set_slave(1 - v.tgt, k == 1, 32'hBAD0BAD0);
            set_slave(v.tgt, k == v.lat, v.srd);
            #1;
            if (m_ack) begin
                got = 1;
                if (sb.size() == 0) chk("unexpected_ack", 1, 0);
                else begin
                    r = sb.pop_front();
                    chk("ack_latency", W'(k), W'(r.lat));
                    chk("ack_err", W'(m_err), W'(r.err));
                    chk("ack_rdata", m_rdata, r.rd);
                end
            end
            @(negedge clk);
        end
        chk("ack_seen", W'(got), 1);
        if (!got && sb.size() > 0) void'(sb.pop_front());
        set_slave(v.tgt, 0, 0);
        set_slave(1 - v.tgt, 0, 0);
        for (int j = 0; j < 3; j++) begin
            if (v.late_ack) set_slave(v.tgt, j == 0, 32'h55555555);
            #1;
            if (m_ack) extra = 1;
            @(negedge clk);
        end
        chk("no_extra_ack", W'(extra), 0);
        set_slave(v.tgt, 0, 0);
        m_cyc = 0; m_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        tbl[0]  = mk(0, 32'h10000008, 0, 0, 0, 1, 32'h44, 0, 1, 1, 0, 32'h44);
        tbl[1]  = mk(1, 32'h20000010, 32'h12345678, 1, 2, 1, 32'hCAFE0001, 0, 0, 1, 0, 32'hCAFE0001);
        tbl[2]  = mk(0, 32'h30000000, 0, -1, 0, 0, 0, 0, 0, 1, 1, ERRD);
        tbl[3]  = mk(0, 32'h10000000, 0, 0, 0, 0, 0, 0, 1, 17, 1, ERRD);
        tbl[4]  = mk(0, 32'h100001FC, 0, 0, 1, 3, 32'h11, 0, 0, 3, 0, 32'h11);
        tbl[5]  = mk(0, 32'h10000200, 0, -1, 0, 0, 0, 0, 0, 1, 1, ERRD);
        tbl[6]  = mk(0, 32'h0FFFFFFC, 0, -1, 0, 0, 0, 0, 0, 1, 1, ERRD);
        tbl[7]  = mk(0, 32'h200001FC, 0, 1, 0, 2, 32'h77, 1, 0, 2, 0, 32'h77);
        tbl[8]  = mk(0, 32'h20000000, 0, 1, 0, 16, 32'h99, 0, 0, 16, 0, 32'h99);
        tbl[9]  = mk(1, 32'hFFFFFFFC, 32'hAAAA5555, -1, 0, 0, 0, 0, 0, 1, 1, ERRD);
        tbl[10] = mk(0, 32'h1FFFFFFC, 0, -1, 0, 0, 0, 0, 0, 1, 1, ERRD);
        tbl[11] = mk(1, 32'h20000200, 32'h1, -1, 0, 0, 0, 0, 0, 1, 1, ERRD);

        // outputs stay quiet while reset is held, even with a request on the bus
        m_cyc = 1; m_stb = 1; m_addr = 32'h10000008; s0_stall = 1;
        #1 chk_quiet("por");
        @(negedge clk);
        @(negedge clk);
        m_cyc = 0; m_stb = 0; s0_stall = 0; reset = 1;
        @(negedge clk);

        foreach (tbl[i]) xfer(tbl[i]);

        // reset pulled during WAIT_ACK
        m_cyc = 1; m_stb = 1; m_addr = 32'h10000000;
        @(negedge clk);
        m_stb = 0;
        @(negedge clk);
        #1 chk("wait_stall", m_stall, 1);
        #1 reset = 0; m_stb = 1; s0_stall = 1; s0_ack = 1;
        #1 chk_quiet("mid_rst");
        @(negedge clk);
        #1 chk_quiet("mid_rst_hold");
        reset = 1; m_stb = 0; s0_stall = 0; s0_ack = 0;
        #1 chk("rst_idle_stall", m_stall, 0);
        chk("rst_idle_ack", m_ack, 0);
        @(negedge clk);
        m_cyc = 0;
        @(negedge clk);
        xfer(tbl[5]);

        // master abort: dropping m_cyc in WAIT_ACK returns to IDLE without an ack
        m_cyc = 1; m_stb = 1; m_addr = 32'h10000000;
        #1 chk("abort_stb", s0_stb, 1);
        @(negedge clk);
        m_stb = 0;
        #1 chk("abort_wait_stall", m_stall, 1);
        @(negedge clk);
        m_cyc = 0; s0_ack = 1; s0_rdata = 32'h12121212;
        #1 chk("abort_ack", m_ack, 0);
        @(negedge clk);
        s0_ack = 0;
        #1 chk("abort_idle_stall", m_stall, 0);
        ab = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 if (m_ack) ab = 1;
        end
        chk("abort_no_ack", W'(ab), 0);
        @(negedge clk);

`ifdef LEIWAND_RV32_WB_DECODER_ERR_STATS_EN
        reset = 0;
        #1 chk("stats_rst_count", W'(err_count), 0);
        chk("stats_rst_addr", err_addr, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        xfer(mk(0, 32'h30000004, 0, -1, 0, 0, 0, 0, 0, 1, 1, ERRD));
        xfer(tbl[0]);
        xfer(mk(0, 32'h1000000C, 0, 0, 0, 0, 0, 0, 0, 17, 1, ERRD));
        chk("stats_count", W'(err_count), 2);
        chk("stats_addr", err_addr, 32'h1000000C);
`endif

        chk("scoreboard_empty", W'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
